// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver and scancode decoder.
// Synchronises and deglitches the keyboard clock, shifts in 11-bit frames,
// aborts stalled frames and folds E0/F0 prefixes into one 11-bit key event.
// Optional build macro: PS2_PARITY_CHECK_EN (enables the odd-parity check).
module ps2_key_decoder #(
    parameter int TIMEOUT_CYC = 24576
) (
    input  logic        I_CLK_24576M,
    input  logic        I_RESETn,
    input  logic        I_PS2_CLK,
    input  logic        I_PS2_DAT,
    output logic [10:0] O_PS2_KEY,
    output logic        O_FRAME_ERR
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [1:0]       r_clk_sync;
    logic [1:0]       r_dat_sync;
    logic             r_clk_filt;
    logic [2:0]       r_flt_cnt;
    logic [1:0]       r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_ext;
    logic             r_brk;
    logic [10:0]      r_key;
    logic             r_frame_err;

    logic w_clk_diff;
    logic w_flt_done;
    logic w_fall;
    logic w_dat;
    logic w_par_ok;
    logic w_ignore;

    // Two-flop synchronisers; both lines idle high so reset to 1
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], I_PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], I_PS2_DAT};
        end
    end

    // A new clock level is accepted on the 8th consecutive cycle it differs
    assign w_clk_diff = (r_clk_sync[1] != r_clk_filt);
    assign w_flt_done = w_clk_diff && (r_flt_cnt == 3'd7);
    assign w_fall     = w_flt_done && r_clk_filt;
    assign w_dat      = r_dat_sync[1];

    // Glitch filter on the synchronised PS/2 clock
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_clk_filt <= 1'b1;
            r_flt_cnt  <= 3'd0;
        end else if (!w_clk_diff) begin
            r_flt_cnt <= 3'd0;
        end else if (w_flt_done) begin
            r_clk_filt <= r_clk_sync[1];
            r_flt_cnt  <= 3'd0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 3'd1;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;

    // Parity bit captured on its falling edge; checked at the stop bit
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_par <= 1'b0;
        end else if (w_fall && (r_state == ST_PARITY)) begin
            r_par <= w_dat;
        end
    end

    assign w_par_ok = ^{r_shift, r_par};
`else
    assign w_par_ok = 1'b1;
`endif

    // Keyboard housekeeping replies are dropped unless a prefix is pending
    assign w_ignore = (r_shift == 8'hAA) || (r_shift == 8'hFA) ||
                      (r_shift == 8'hEE) || (r_shift == 8'hFE) ||
                      (r_shift == 8'h00) || (r_shift == 8'hFF);

    // Frame FSM, stall timeout and prefix/event decoding
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_tmo_cnt   <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_key       <= 11'h000;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if ((r_state != ST_IDLE) && !w_fall) begin
                // Stalled mid-frame: drop the partial byte, keep the prefixes
                if (r_tmo_cnt == TMO_LIM) begin
                    r_state     <= ST_IDLE;
                    r_tmo_cnt   <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
            end else if (w_fall) begin
                r_tmo_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!w_dat) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_shift <= {w_dat, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        r_state <= ST_STOP;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        if (!(w_dat && w_par_ok)) begin
                            r_frame_err <= 1'b1;
                        end else if (r_shift == 8'hE0) begin
                            r_ext <= 1'b1;
                        end else if (r_shift == 8'hF0) begin
                            r_brk <= 1'b1;
                        end else if (!(w_ignore && !r_ext && !r_brk)) begin
                            r_key <= {~r_key[10], ~r_brk, r_ext, r_shift};
                            r_ext <= 1'b0;
                            r_brk <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign O_PS2_KEY   = r_key;
    assign O_FRAME_ERR = r_frame_err;

endmodule
